// File: rtl/pio_pc_bank.sv
// Per-lane PIO program counters: wrap, jump, hold, stall and host write.
// Define PIO_PC_CALL_STACK_EN to add a per-lane call/return stack.
module pio_pc_bank #(
    parameter int NUM_SM      = 4,
    parameter int ADDR_W      = 5,
    parameter int STACK_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SM-1:0]        penable,
    input  logic [NUM_SM-1:0]        stalled,
    input  logic [NUM_SM-1:0]        imm,
    input  logic [NUM_SM-1:0]        jmp,
    input  logic [NUM_SM*ADDR_W-1:0] jmp_target,
    input  logic [NUM_SM*ADDR_W-1:0] wrap_top,
    input  logic [NUM_SM*ADDR_W-1:0] wrap_target,
    input  logic [NUM_SM-1:0]        pc_wr,
    input  logic [ADDR_W-1:0]        pc_wr_data,
`ifdef PIO_PC_CALL_STACK_EN
    input  logic [NUM_SM-1:0]        call,
    input  logic [NUM_SM-1:0]        ret,
    input  logic [NUM_SM-1:0]        err_clr,
    output logic [NUM_SM-1:0]        stack_err,
`endif
    output logic [NUM_SM*ADDR_W-1:0] pc,
    output logic [NUM_SM*ADDR_W-1:0] pc_next,
    output logic [NUM_SM-1:0]        wrapped
);

    if (NUM_SM < 1 || NUM_SM > 8 || ADDR_W < 4 || ADDR_W > 8
        || STACK_DEPTH < 1 || STACK_DEPTH > 4) begin : g_bad_param
        $error("pio_pc_bank: parameter out of range");
    end

`ifdef PIO_PC_CALL_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
`endif

    for (genvar i = 0; i < NUM_SM; i++) begin : g_lane
        logic [ADDR_W-1:0] pc_q;
        logic [ADDR_W-1:0] nxt;
        logic [ADDR_W-1:0] seq;
        logic [ADDR_W-1:0] jt;
        logic [ADDR_W-1:0] top;
        logic [ADDR_W-1:0] tgt;
        logic              adv;
        logic              take_seq;
        logic              wrap_q;

        assign jt  = jmp_target[i*ADDR_W +: ADDR_W];
        assign top = wrap_top[i*ADDR_W +: ADDR_W];
        assign tgt = wrap_target[i*ADDR_W +: ADDR_W];
        assign adv = (penable[i] | imm[i]) & ~stalled[i];
        assign seq = (pc_q == top) ? tgt : pc_q + 1'b1;

`ifdef PIO_PC_CALL_STACK_EN
        logic [ADDR_W-1:0] stk [STACK_DEPTH];
        logic [ADDR_W-1:0] stk_top;
        logic [SP_W-1:0]   sp;
        logic              err_q;
        logic              do_ret;
        logic              do_call;
        logic              empty;
        logic              full;
        logic              err_set;

        // A host write outranks call/ret, so the stack is left untouched.
        assign do_ret  = ~pc_wr[i] & adv & ret[i];
        assign do_call = ~pc_wr[i] & adv & call[i] & ~ret[i];
        assign empty   = (sp == '0);
        assign full    = (sp == SP_W'(STACK_DEPTH));
        assign err_set = (do_ret & empty) | (do_call & full);

        always_comb begin
            stk_top = '0;
            for (int j = 0; j < STACK_DEPTH; j++) begin
                if (sp == SP_W'(j + 1)) stk_top = stk[j];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sp    <= '0;
                err_q <= 1'b0;
            end else begin
                if (do_ret) begin
                    if (!empty) sp <= sp - 1'b1;
                end else if (do_call) begin
                    if (full) begin
                        // Drop the oldest entry; the push still lands on top.
                        for (int j = 0; j < STACK_DEPTH - 1; j++) begin
                            stk[j] <= stk[j + 1];
                        end
                        stk[STACK_DEPTH-1] <= seq;
                    end else begin
                        for (int j = 0; j < STACK_DEPTH; j++) begin
                            if (sp == SP_W'(j)) stk[j] <= seq;
                        end
                        sp <= sp + 1'b1;
                    end
                end
                if (err_set) err_q <= 1'b1;
                else if (err_clr[i]) err_q <= 1'b0;
            end
        end

        assign stack_err[i] = err_q;
`endif

        always_comb begin
            nxt      = pc_q;
            take_seq = 1'b0;
            if (pc_wr[i]) begin
                nxt = pc_wr_data;
`ifdef PIO_PC_CALL_STACK_EN
            end else if (do_ret) begin
                nxt = empty ? seq : stk_top;
            end else if (do_call) begin
                nxt = jt;
`endif
            end else if (adv & jmp[i]) begin
                nxt = jt;
            end else if (adv & imm[i]) begin
                nxt = pc_q;
            end else if (adv) begin
                nxt      = seq;
                take_seq = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pc_q   <= '0;
                wrap_q <= 1'b0;
            end else begin
                pc_q   <= nxt;
                wrap_q <= take_seq & (pc_q == top);
            end
        end

        assign pc[i*ADDR_W +: ADDR_W]      = pc_q;
        assign pc_next[i*ADDR_W +: ADDR_W] = nxt;
        assign wrapped[i]                  = wrap_q;
    end

endmodule

// File: doc/pio_pc_bank.md
Name: pio_pc_bank

Overview:
Bank of NUM_SM independent program counters for the PIO block, one per state machine, with a shared clock and reset and a parametrised instruction-memory address width.
Each lane supports:
- sequential advance with wrap_top→wrap_target wrapping
- jumps
- immediate-instruction hold
- stall
- host PC write
- a registered wrap-event pulse
An optional per-lane call/return stack is also available. The bank sits between the instruction decoder and instruction memory; pc_next drives memory addressing.

Parameters:
NUM_SM, 4, number of state-machine lanes (1..8)
ADDR_W, 5, PC / instruction address width (4..8)
STACK_DEPTH, 2, call-stack entries per lane; only used with PIO_PC_CALL_STACK_EN (1..4)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high; clears all lanes
penable  input  NUM_SM  lane i enabled this cycle
stalled  input  NUM_SM  lane i instruction stalled
imm  input  NUM_SM  lane i executing a forced/immediate instruction
jmp  input  NUM_SM  lane i takes jump
jmp_target  input  NUM_SM*ADDR_W  lane i jump target, bits [i*ADDR_W +: ADDR_W]
wrap_top  input  NUM_SM*ADDR_W  lane i wrap source address
wrap_target  input  NUM_SM*ADDR_W  lane i wrap destination address
pc_wr  input  NUM_SM  host write strobe for lane i
pc_wr_data  input  ADDR_W  host write value, shared by all lanes
pc  output  NUM_SM*ADDR_W  registered current PC per lane
pc_next  output  NUM_SM*ADDR_W  combinational value PC takes at next edge (reset excluded)
wrapped  output  NUM_SM  registered one-cycle pulse: lane wrapped on previous edge

Behaviour:
- Reset: every pc = 0, wrapped = 0; with the optional feature, stack pointers = 0 and stack_err = 0. Reset overrides all other inputs.
- Per lane i: adv = (penable[i] | imm[i]) & ~stalled[i]. Sequential successor seq = (pc == wrap_top) ? wrap_target : pc + 1, mod 2^ADDR_W, so pc = 2^ADDR_W−1 with no wrap match rolls to 0.
- Next-PC priority, highest first:
  1. pc_wr[i] → pc_wr_data, regardless of adv/stall.
  2. adv & jmp → jmp_target. This applies even when imm=1.
  3. adv & imm → pc held.
  4. adv → seq.
  5. otherwise → pc held.
- pc_next[i] equals the selected value combinationally; pc[i] registers it at the edge. PC update latency is 1 cycle.
- wrapped[i] <= 1 iff the lane took priority 4 and pc == wrap_top; otherwise 0.
  - A jump to wrap_target, or a host write, does not set wrapped.
- wrap_top == wrap_target: a lane sitting on that address holds and pulses wrapped every advancing cycle.
- Lanes are fully independent. Multiple simultaneous pc_wr strobes all load the same pc_wr_data.
- Reset asserted mid-stall or mid-jump: pc = 0 on the next cycle, with no pending state retained.

Optional Feature:
Macro PIO_PC_CALL_STACK_EN.
- When defined, adds ports:
  - call input NUM_SM
  - ret input NUM_SM
  - stack_err output NUM_SM (registered, sticky)
  - err_clr input NUM_SM
- Each lane gets a STACK_DEPTH-entry LIFO of ADDR_W bits.
- Priority inserted below pc_wr and above jmp, in order ret, call:
  - adv & ret: if stack is non-empty, pop the top into pc. If empty, pc ← seq and stack_err set.
  - adv & call: push seq, pc ← jmp_target. If full, the oldest entry is discarded (the stack shifts), the push still completes, and stack_err is set.
  - ret and call together: ret wins; call is ignored.
- pc_wr does not modify the stack.
- stack_err clears only on reset or err_clr[i]. If a set condition and err_clr occur in the same cycle, set wins.
- Without the macro: none of these ports or registers exist, and behaviour is exactly the base priority list.

Test Plan:
- Reset then penable=1 on lane 0, wrap_top=3, wrap_target=1 → pc sequence 0,1,2,3,1,2; wrapped pulses one cycle after each 3→1 transition.
- Lane 1 at pc=2, jmp=1, jmp_target=17, imm=1, stalled=0 → pc=17 next cycle. Same with stalled=1 → pc stays 2 and pc_next=2.
- imm=1, penable=0, jmp=0 at pc=5 → pc holds 5. Then penable=0, imm=0 → pc holds 5.
- ADDR_W=5, pc=31, wrap_top=10 → pc=0 next cycle, no wrapped pulse. pc_wr=1, pc_wr_data=9 with adv & jmp in the same cycle → pc=9.
- Lanes 0 and 3 advancing with different wrap bounds while lane 2 is stalled → lanes 0 and 3 independent, lane 2 constant. Reset mid-run → all pc=0 next cycle.
- (PIO_PC_CALL_STACK_EN, STACK_DEPTH=2)
  - Calls from pc=4, 7, 9 to target 20 → third call sets stack_err.
  - Three rets → pc 10, 8, then seq with stack_err still 1.
  - err_clr → stack_err 0.
